regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between several writeback requesters (ALU result, load unit, CSR/misc unit). Each cycle, round-robin arbitration grants at most one requester. The winning address and data are registered and driven onto the register file write port one cycle later. The block also exports a pending-write mask for the hazard logic and a hold input for pipeline stalls.

---
 rtl/regfile_write_arbiter_if.sv | 23 ++
 rtl/regfile_write_arbiter.sv | 83 ++++++++
 tb/tb_regfile_write_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the requesters, the arbiter and the register file write port.
// The master side drives requests and hold; the slave side (the arbiter) drives the rest.
interface regfile_write_arbiter_if #(parameter int NUM_REQ = 3);
   logic                      wb_hold;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0][4:0]   req_addr;
   logic [NUM_REQ-1:0][31:0]  req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [4:0]                write_reg_addr;
   logic [31:0]               write_data;
   logic                      write_enable;
   logic [31:0]               pending_mask;

   modport master (
      output wb_hold, req_valid, req_addr, req_data,
      input  req_ready, write_reg_addr, write_data, write_enable, pending_mask
   );

   modport slave (
      input  wb_hold, req_valid, req_addr, req_data,
      output req_ready, write_reg_addr, write_data, write_enable, pending_mask
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register file write port.
// One registered output stage; x0 writes are accepted but never enabled.
module regfile_write_arbiter #(
   parameter int NUM_REQ = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   regfile_write_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef logic [4:0]  reg_index_t;
   typedef logic [31:0] reg_data_t;

   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   next_ptr;
   logic               grant;
   logic [NUM_REQ-1:0] ready;
   int                 idx;
   reg_index_t         win_addr;
   reg_data_t          win_data;
   logic               out_en;
   reg_index_t         out_addr;
   reg_data_t          out_data;
   logic [31:0]        pend;

   // Search starts at rr_ptr and wraps; ready is held low during reset.
   always_comb begin
      ready     = '0;
      grant     = 1'b0;
      grant_idx = '0;
      idx       = 0;
      if (reset && !bus.wb_hold) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant && bus.req_valid[idx]) begin
               grant     = 1'b1;
               grant_idx = PTR_W'(idx);
            end
         end
      end
      if (grant) ready[grant_idx] = 1'b1;
   end

   assign next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
   assign win_addr = bus.req_addr[grant_idx];
   assign win_data = bus.req_data[grant_idx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr   <= '0;
         out_en   <= 1'b0;
         out_addr <= '0;
         out_data <= '0;
      end else begin
         out_en <= grant && (win_addr != '0);
         if (grant) begin
            rr_ptr <= next_ptr;
            if (win_addr != '0) begin
               out_addr <= win_addr;
               out_data <= win_data;
            end
         end
      end
   end

   // Hazard view: every presented request plus the write sitting in the output register.
   always_comb begin
      pend = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (bus.req_valid[i]) pend[bus.req_addr[i]] = 1'b1;
      if (out_en) pend[out_addr] = 1'b1;
      pend[0] = 1'b0;
   end

   assign bus.req_ready      = ready;
   assign bus.write_enable   = out_en;
   assign bus.write_reg_addr = out_addr;
   assign bus.write_data     = out_data;
   assign bus.pending_mask   = pend;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed test-plan steps followed by a randomized run, all checked against a
// behavioural model (search order, queued register file contents, fairness bound).
module tb_regfile_write_arbiter;
   localparam int N = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   regfile_write_arbiter_if #(.NUM_REQ(N)) bus();
   regfile_write_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   int          m_rr;
   logic        m_en;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic [31:0] m_rf [32];
   logic [31:0] rf   [32];

   int          last_grant;
   logic [31:0] last_rdy, last_we, last_addr, last_data, last_pend;
   int          wait_cnt [N];

   // Register file fed by the DUT write port.
   always @(posedge clk) if (bus.write_enable) rf[bus.write_reg_addr] <= bus.write_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_grant();
      if (!reset || bus.wb_hold) return -1;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_rr + k) % N;
         if (bus.req_valid[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [31:0] exp_pending();
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < N; i++) if (bus.req_valid[i]) m[bus.req_addr[i]] = 1'b1;
      if (m_en) m[m_addr] = 1'b1;
      m[0] = 1'b0;
      return m;
   endfunction

   function automatic void model_reset();
      m_rr = 0; m_en = 1'b0; m_addr = '0; m_data = '0;
   endfunction

   // Called just after a falling edge with inputs already applied.
   task automatic cycle(input string tag);
      int g;
      logic [31:0] rdy;
      #1;
      g   = exp_grant();
      rdy = (g < 0) ? 32'd0 : (32'd1 << g);
      last_rdy  = 32'(bus.req_ready);
      last_we   = 32'(bus.write_enable);
      last_addr = 32'(bus.write_reg_addr);
      last_data = bus.write_data;
      last_pend = bus.pending_mask;
      check({tag, ".ready"}, last_rdy, rdy);
      check({tag, ".pend"},  last_pend, exp_pending());
      check({tag, ".we"},    last_we, 32'(m_en));
      if (m_en) begin
         check({tag, ".addr"}, last_addr, 32'(m_addr));
         check({tag, ".data"}, last_data, m_data);
      end
      last_grant = g;
      @(posedge clk);
      if (m_en) m_rf[m_addr] = m_data;
      if (reset) begin
         m_en = 1'b0;
         if (g >= 0) begin
            m_rr = (g + 1) % N;
            if (bus.req_addr[g] != 5'd0) begin
               m_en = 1'b1; m_addr = bus.req_addr[g]; m_data = bus.req_data[g];
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      bus.req_valid = '0;
      bus.wb_hold   = 1'b0;
      cycle("rstp");
      reset = 1'b1;
   endtask

   logic [31:0] gr [6];
   logic [31:0] wa [7];
   logic [31:0] wd [7];

   initial begin
      for (int i = 0; i < 32; i++) begin rf[i] = '0; m_rf[i] = '0; end
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      last_grant = -1;
      model_reset();
      reset = 1'b0;
      bus.wb_hold = 1'b0;
      bus.req_valid = '1;
      for (int i = 0; i < N; i++) begin bus.req_addr[i] = 5'd5; bus.req_data[i] = 32'h100 + i; end
      @(negedge clk);

      // Reset held with all requesters valid on x5
      cycle("rst");
      check("rst.ready0", last_rdy, 32'd0);
      check("rst.we0",    last_we,  32'd0);
      check("rst.pend",   last_pend, 32'h20);
      reset = 1'b1;
      cycle("rel");
      check("rel.first_grant", last_rdy, 32'd1);
      bus.req_valid = '0;
      cycle("rel2");
      check("rel.we",   last_we, 32'd1);
      check("rel.addr", last_addr, 32'd5);

      // Round-robin with all three valid
      do_reset();
      for (int i = 0; i < N; i++) begin
         bus.req_addr[i] = 5'(i + 1); bus.req_data[i] = 32'hA + i;
      end
      bus.req_valid = '1;
      for (int k = 0; k < 7; k++) begin
         if (k == 6) bus.req_valid = '0;
         cycle("rr");
         if (k < 6) gr[k] = last_rdy;
         wa[k] = last_we ? last_addr : 32'hFFFF;
         wd[k] = last_data;
      end
      for (int k = 0; k < 6; k++) begin
         check("rr.grant", gr[k], 32'd1 << (k % 3));
         check("rr.waddr", wa[k + 1], 32'(k % 3 + 1));
         check("rr.wdata", wd[k + 1], 32'hA + k % 3);
      end

      // x0 discard
      bus.req_valid = 3'b010; bus.req_addr[1] = 5'd0; bus.req_data[1] = 32'hDEADBEEF;
      cycle("x0");
      check("x0.ready", last_rdy, 32'd2);
      check("x0.pend",  last_pend, 32'd0);
      bus.req_valid = '0;
      cycle("x0b");
      check("x0.we",    last_we, 32'd0);
      check("x0.pend2", last_pend, 32'd0);

      // Hold: port 2 granted just before the hold leaves rr_ptr at 0
      do_reset();
      bus.req_valid = 3'b100; bus.req_addr[2] = 5'd10; bus.req_data[2] = 32'h77;
      cycle("pre");
      check("pre.ready", last_rdy, 32'd4);
      bus.req_valid = 3'b101;
      bus.req_addr[0] = 5'd4; bus.req_data[0] = 32'h44;
      bus.req_addr[2] = 5'd6; bus.req_data[2] = 32'h66;
      bus.wb_hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle("hold");
         check("hold.ready", last_rdy, 32'd0);
         check("hold.we", last_we, (k == 0) ? 32'd1 : 32'd0);
         if (k == 0) check("hold.commit_addr", last_addr, 32'd10);
      end
      bus.wb_hold = 1'b0;
      cycle("hrel");
      check("hrel.first", last_rdy, 32'd1);
      bus.req_valid = 3'b100;
      cycle("hrel2");
      check("hrel.second", last_rdy, 32'd4);
      bus.req_valid = '0;
      cycle("hrel3");

      // Same-rd conflict on x7
      do_reset();
      bus.req_valid = 3'b011;
      bus.req_addr[0] = 5'd7; bus.req_data[0] = 32'h11;
      bus.req_addr[1] = 5'd7; bus.req_data[1] = 32'h22;
      cycle("rd7a");
      check("rd7.g0", last_rdy, 32'd1);
      bus.req_valid = 3'b010;
      cycle("rd7b");
      check("rd7.g1", last_rdy, 32'd2);
      check("rd7.w0", last_data, 32'h11);
      bus.req_valid = '0;
      cycle("rd7c");
      check("rd7.w1", last_data, 32'h22);
      cycle("rd7d");
      check("rd7.read", rf[7], 32'h22);

      // Mid-write reset: granted write to x9 must never land
      bus.req_valid = 3'b100; bus.req_addr[2] = 5'd9; bus.req_data[2] = 32'h55;
      cycle("mw");
      check("mw.grant", last_rdy, 32'd4);
      bus.req_valid = '0;
      reset = 1'b0;
      model_reset();
      #1;
      check("mw.we_drop", 32'(bus.write_enable), 32'd0);
      cycle("mw2");
      check("mw.no_x9", rf[9], 32'd0);
      reset = 1'b1;

      // Randomized run honouring the requester contract
      do_reset();
      last_grant = -1;
      for (int c = 0; c < 400; c++) begin
         bus.wb_hold = ($urandom_range(0, 4) == 0);
         for (int i = 0; i < N; i++) begin
            if (!bus.req_valid[i] || last_grant == i) begin
               bus.req_valid[i] = ($urandom_range(0, 2) != 0);
               bus.req_addr[i]  = 5'($urandom_range(0, 7));
               bus.req_data[i]  = $urandom;
               wait_cnt[i] = 0;
            end
         end
         cycle("rnd");
         for (int i = 0; i < N; i++) begin
            if (bus.req_valid[i] && last_grant == i)
               check("rnd.wait", 32'(wait_cnt[i] <= N - 1), 32'd1);
            else if (bus.req_valid[i] && !bus.wb_hold)
               wait_cnt[i]++;
         end
      end
      bus.req_valid = '0;
      bus.wb_hold = 1'b0;
      cycle("drain");
      cycle("drain2");
      for (int r = 0; r < 32; r++) check("rf.final", rf[r], m_rf[r]);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
